// File: rtl/data_sram_arbiter_if.sv
// rtl/data_sram_arbiter_if.sv - requester-side request/response channel of the data SRAM arbiter
interface data_sram_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req;
   logic                  wr;
   logic [DATA_W/8-1:0]   wstrb;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic                  addr_ok;
   logic                  data_ok;
   logic [DATA_W-1:0]     rdata;

   modport master (
      output req, wr, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/data_sram_arbiter.sv
// rtl/data_sram_arbiter.sv - two-requester round-robin arbiter for the single-port data SRAM
// One access issued per cycle; the response (read data or write ack) returns one cycle later.
module data_sram_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RR_EN  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   data_sram_arbiter_if.slave   p0,
   data_sram_arbiter_if.slave   p1,
   output logic                 data_sram_en,
   output logic [DATA_W/8-1:0]  data_sram_we,
   output logic [ADDR_W-1:0]    data_sram_addr,
   output logic [DATA_W-1:0]    data_sram_wdata,
   input  logic [DATA_W-1:0]    data_sram_rdata
);

   logic last_gnt;
   logic resp_vld;
   logic resp_id;
   logic resp_wr;

   logic gnt_vld;
   logic gnt_id;
   logic gnt_wr;

   // Grant is suppressed during reset so nothing is accepted or issued.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (p0.req && p1.req) begin
         gnt_vld = 1'b1;
         gnt_id  = (RR_EN != 0) ? ~last_gnt : 1'b0;
      end else if (p0.req) begin
         gnt_vld = 1'b1;
      end else if (p1.req) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b1;
      end
      if (rst) begin
         gnt_vld = 1'b0;
      end
   end

   assign gnt_wr = gnt_id ? p1.wr : p0.wr;

   assign p0.addr_ok = gnt_vld & ~gnt_id;
   assign p1.addr_ok = gnt_vld &  gnt_id;

   assign data_sram_en    = gnt_vld;
   assign data_sram_addr  = (gnt_vld && gnt_id) ? p1.addr  : p0.addr;
   assign data_sram_wdata = (gnt_vld && gnt_id) ? p1.wdata : p0.wdata;
   assign data_sram_we    = (gnt_vld && gnt_wr) ? (gnt_id ? p1.wstrb : p0.wstrb) : '0;

   // last_gnt resets to 1 so the first tie after reset goes to port 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt <= 1'b1;
         resp_vld <= 1'b0;
         resp_id  <= 1'b0;
         resp_wr  <= 1'b0;
      end else if (gnt_vld) begin
         last_gnt <= gnt_id;
         resp_vld <= 1'b1;
         resp_id  <= gnt_id;
         resp_wr  <= gnt_wr;
      end else begin
         resp_vld <= 1'b0;
      end
   end

   assign p0.data_ok = resp_vld & ~resp_id;
   assign p1.data_ok = resp_vld &  resp_id;

   assign p0.rdata = (p0.data_ok && !resp_wr) ? data_sram_rdata : '0;
   assign p1.rdata = (p1.data_ok && !resp_wr) ? data_sram_rdata : '0;

endmodule
